// File: rtl/scm_bist_ctrl.sv
// ============================================================================
// Module   : scm_bist_ctrl
// Function : LFSR write/read-back self-test engine for a standard-cell memory.
//            Optional inverted second pass enabled by SCM_BIST_INVERT_PASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scm_bist_ctrl #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [15:0]           SEED,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASS,
    output logic [CNT_WIDTH-1:0]  ERR_CNT,
    output logic [ADDR_WIDTH-1:0] FIRST_FAIL_ADDR,
    output logic                  MEM_WE,
    output logic [ADDR_WIDTH-1:0] MEM_WADDR,
    output logic [DATA_WIDTH-1:0] MEM_DIN,
    output logic                  MEM_RE,
    output logic [ADDR_WIDTH-1:0] MEM_RADDR,
    output logic                  MEM_SE,
    input  logic [DATA_WIDTH-1:0] MEM_DOUT
);

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;

`ifdef SCM_BIST_INVERT_PASS_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_WRITE_INV, S_READ_INV, S_DRAIN, S_FINISH
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_DRAIN, S_FINISH
    } state_t;
`endif

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [2:0]              drain_cnt;
    logic [15:0]             lfsr;
    logic [15:0]             lfsr_nxt;
    logic [15:0]             seed_q;
    logic [15:0]             seed_eff;
    logic                    start_ok;
    logic                    seq_state;
    logic                    wr_nxt;
    logic                    rd_nxt;
    logic                    inv_nxt;
    logic                    inv_cur;
    logic                    addr_last;
    logic                    mismatch;
    logic [CNT_WIDTH-1:0]    err_nxt;

    logic [READ_LATENCY:1]   pv;
    logic [DATA_WIDTH-1:0]   pexp  [1:READ_LATENCY];
    logic [ADDR_WIDTH-1:0]   paddr [1:READ_LATENCY];

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // Seed replicated across the word; the top replica is truncated when needed.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [15:0] s, input logic inv);
        logic [DATA_WIDTH-1:0] w;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w[i] = s[i[3:0]] ^ inv;
        end
        return w;
    endfunction

    assign seed_eff  = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
    assign addr_last = &addr;
    assign MEM_WADDR = addr;
    assign MEM_RADDR = addr;
    assign MEM_SE    = 1'b0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        seq_state = 1'b0;
        wr_nxt    = 1'b0;
        rd_nxt    = 1'b0;
        inv_nxt   = 1'b0;
        inv_cur   = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_WRITE;
                    start_ok  = 1'b1;
                end
            end
            S_WRITE: begin
                seq_state = 1'b1;
                if (addr_last) state_nxt = S_READ;
            end
            S_READ: begin
                seq_state = 1'b1;
`ifdef SCM_BIST_INVERT_PASS_EN
                if (addr_last) state_nxt = S_WRITE_INV;
`else
                if (addr_last) state_nxt = S_DRAIN;
`endif
            end
`ifdef SCM_BIST_INVERT_PASS_EN
            S_WRITE_INV: begin
                seq_state = 1'b1;
                if (addr_last) state_nxt = S_READ_INV;
            end
            S_READ_INV: begin
                seq_state = 1'b1;
                inv_cur   = 1'b1;
                if (addr_last) state_nxt = S_DRAIN;
            end
`endif
            S_DRAIN: begin
                if (drain_cnt == 3'(READ_LATENCY - 1)) state_nxt = S_FINISH;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase

        wr_nxt = (state_nxt == S_WRITE);
        rd_nxt = (state_nxt == S_READ);
`ifdef SCM_BIST_INVERT_PASS_EN
        wr_nxt  = wr_nxt | (state_nxt == S_WRITE_INV);
        rd_nxt  = rd_nxt | (state_nxt == S_READ_INV);
        inv_nxt = (state_nxt == S_WRITE_INV) || (state_nxt == S_READ_INV);
`endif
    end

    // Each phase ends by reloading the seed so the next phase replays the stream.
    always_comb begin
        lfsr_nxt = lfsr;
        if (start_ok) begin
            lfsr_nxt = seed_eff;
        end else if (seq_state) begin
            lfsr_nxt = addr_last ? seed_q : lfsr_step(lfsr);
        end
    end

    assign mismatch = pv[READ_LATENCY] && (MEM_DOUT != pexp[READ_LATENCY]);

    always_comb begin
        err_nxt = ERR_CNT;
        if (start_ok) begin
            err_nxt = '0;
        end else if (mismatch && (ERR_CNT != '1)) begin
            err_nxt = ERR_CNT + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr            <= '0;
            drain_cnt       <= '0;
            lfsr            <= '0;
            seed_q          <= '0;
            pv              <= '0;
            BUSY            <= 1'b0;
            DONE            <= 1'b0;
            PASS            <= 1'b0;
            ERR_CNT         <= '0;
            FIRST_FAIL_ADDR <= '0;
            MEM_WE          <= 1'b0;
            MEM_RE          <= 1'b0;
            MEM_DIN         <= '0;
        end else begin
            lfsr    <= lfsr_nxt;
            ERR_CNT <= err_nxt;
            MEM_WE  <= wr_nxt;
            MEM_RE  <= rd_nxt;
            BUSY    <= (state_nxt != S_IDLE) && (state_nxt != S_FINISH);
            if (start_ok) begin
                seed_q <= seed_eff;
            end
            if (start_ok) begin
                addr <= '0;
            end else if (seq_state) begin
                addr <= addr + ADDR_WIDTH'(1);
            end
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 3'd1 : 3'd0;
            if (wr_nxt) begin
                MEM_DIN <= pattern(lfsr_nxt, inv_nxt);
            end
            if (start_ok) begin
                DONE <= 1'b0;
                PASS <= 1'b0;
            end else if (state_nxt == S_FINISH) begin
                DONE <= 1'b1;
                PASS <= (err_nxt == '0);
            end
            if (start_ok) begin
                FIRST_FAIL_ADDR <= '0;
            end else if (mismatch && (ERR_CNT == '0)) begin
                FIRST_FAIL_ADDR <= paddr[READ_LATENCY];
            end
            pv[1] <= MEM_RE;
            for (int i = 2; i <= READ_LATENCY; i++) begin
                pv[i] <= pv[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        pexp[1]  <= pattern(lfsr, inv_cur);
        paddr[1] <= addr;
        for (int i = 2; i <= READ_LATENCY; i++) begin
            pexp[i]  <= pexp[i-1];
            paddr[i] <= paddr[i-1];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scm_bist_ctrl.sv
// Directed bench for scm_bist_ctrl: 16-row memory models with 1- and 2-cycle read latency.
`default_nettype none

module tb_scm_bist_ctrl;

    localparam int N = 16;
`ifdef SCM_BIST_INVERT_PASS_EN
    localparam int NP = 2;
`else
    localparam int NP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        busy, done, pass, mem_we, mem_re, mem_se;
    logic [3:0]  err_cnt, ffa, mem_waddr, mem_raddr;
    logic [63:0] mem_din;
    logic [63:0] mem_dout = '0;

    logic        start2 = 1'b0;
    logic        busy2, done2, pass2, mem_we2, mem_re2, mem_se2;
    logic [3:0]  err_cnt2, ffa2, mem_waddr2, mem_raddr2;
    logic [63:0] mem_din2;
    logic [63:0] mem_dout2 = '0;
    logic [63:0] dout2_a = '0;

    logic [63:0] mem  [0:N-1];
    logic [63:0] mem2 [0:N-1];
    logic [63:0] ref_log [0:2*N-1];
    int          fmode = 0;
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    scm_bist_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .READ_LATENCY(1), .CNT_WIDTH(4)) dut (
        .CLK(clk), .RST(rst), .START(start), .SEED(seed), .BUSY(busy), .DONE(done),
        .PASS(pass), .ERR_CNT(err_cnt), .FIRST_FAIL_ADDR(ffa), .MEM_WE(mem_we),
        .MEM_WADDR(mem_waddr), .MEM_DIN(mem_din), .MEM_RE(mem_re), .MEM_RADDR(mem_raddr),
        .MEM_SE(mem_se), .MEM_DOUT(mem_dout)
    );

    scm_bist_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .READ_LATENCY(2), .CNT_WIDTH(4)) dut2 (
        .CLK(clk), .RST(rst), .START(start2), .SEED(16'hACE1), .BUSY(busy2), .DONE(done2),
        .PASS(pass2), .ERR_CNT(err_cnt2), .FIRST_FAIL_ADDR(ffa2), .MEM_WE(mem_we2),
        .MEM_WADDR(mem_waddr2), .MEM_DIN(mem_din2), .MEM_RE(mem_re2), .MEM_RADDR(mem_raddr2),
        .MEM_SE(mem_se2), .MEM_DOUT(mem_dout2)
    );

    function automatic logic [63:0] flt(input int md, input logic [3:0] a);
        if (md == 1 && a == 4'd5) return 64'd1;
        if (md == 2) return '1;
        return '0;
    endfunction

    function automatic logic [15:0] step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_din;
        if (mem_re) mem_dout <= mem[mem_raddr] ^ flt(fmode, mem_raddr);
        if (mem_we2) mem2[mem_waddr2] <= mem_din2;
        if (mem_re2) dout2_a <= mem2[mem_raddr2];
        mem_dout2 <= dout2_a;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full test on dut; every write is compared against a software LFSR.
    task automatic run(input logic [15:0] sd, input int md, input bit poke,
                       input bit save_log, input bit cmp_log, input int exp_err,
                       input logic [3:0] exp_ffa, input logic exp_pass);
        int cyc, wcnt, rcnt;
        logic [15:0] m, s0;
        logic [63:0] w;
        fmode = md;
        s0 = (sd == 16'h0000) ? 16'hACE1 : sd;
        m = s0;
        @(negedge clk); start = 1'b1; seed = sd;
        @(negedge clk); start = 1'b0;
        cyc = 0; wcnt = 0; rcnt = 0;
        chk("busy_c0", {63'd0, busy}, 64'd1);
        while (!done && cyc < 300) begin
            if (poke && cyc == 3) begin start = 1'b1; seed = 16'h1234; end
            if (poke && cyc == 4) start = 1'b0;
            if (mem_we) begin
                w = {4{m}} ^ (((wcnt / N) % 2 == 1) ? '1 : 64'd0);
                chk("waddr", {60'd0, mem_waddr}, 64'(wcnt % N));
                chk("din", mem_din, w);
                if (save_log) ref_log[wcnt] = mem_din;
                if (cmp_log) chk("din_vs_ace1", mem_din, ref_log[wcnt]);
                m = (wcnt % N == N - 1) ? s0 : step(m);
                wcnt++;
            end
            if (mem_re) rcnt++;
            @(negedge clk); cyc++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
        chk("done_cycle", 64'(cyc), 64'(2 * N * NP + 1));
        chk("writes", 64'(wcnt), 64'(N * NP));
        chk("reads", 64'(rcnt), 64'(N * NP));
        chk("busy_done", {63'd0, busy}, 64'd0);
        chk("pass", {63'd0, pass}, {63'd0, exp_pass});
        chk("err_cnt", {60'd0, err_cnt}, 64'(exp_err));
        chk("ffa", {60'd0, ffa}, {60'd0, exp_ffa});
        @(negedge clk);
        chk("done_sticky", {63'd0, done}, 64'd1);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_pass", {63'd0, pass}, 64'd0);
        chk("rst_err", {60'd0, err_cnt}, 64'd0);
        chk("rst_ffa", {60'd0, ffa}, 64'd0);
        chk("rst_we_re_se", {61'd0, mem_we, mem_re, mem_se}, 64'd0);
        chk("rst_din", mem_din, 64'd0);
        rst = 1'b0;

        // First write carries the seed, the second is one hand-stepped LFSR value.
        @(negedge clk); start = 1'b1; seed = 16'hACE1;
        @(negedge clk); start = 1'b0;
        chk("c0_din", mem_din, 64'hACE1ACE1ACE1ACE1);
        @(negedge clk);
        chk("c1_din_lo", {48'd0, mem_din[15:0]}, 64'h0000_0000_0000_E270);
        chk("c1_waddr", {60'd0, mem_waddr}, 64'd1);
        rst = 1'b1; @(negedge clk); rst = 1'b0;

        run(16'hACE1, 0, 1'b0, 1'b1, 1'b0, 0, 4'd0, 1'b1);
        run(16'hACE1, 1, 1'b0, 1'b0, 1'b0, NP, 4'd5, 1'b0);
        run(16'hACE1, 2, 1'b0, 1'b0, 1'b0, 15, 4'd0, 1'b0);
        run(16'hACE1, 0, 1'b1, 1'b0, 1'b0, 0, 4'd0, 1'b1);
        run(16'h0000, 0, 1'b0, 1'b0, 1'b1, 0, 4'd0, 1'b1);

        // Abort mid-write with RST held during cycle 7.
        @(negedge clk); start = 1'b1; seed = 16'h5A5A;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_pre_we", {63'd0, mem_we}, 64'd1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_we", {63'd0, mem_we}, 64'd0);
        chk("abort_re", {63'd0, mem_re}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        run(16'hACE1, 0, 1'b0, 1'b0, 1'b0, 0, 4'd0, 1'b1);

        // Two-cycle memory on the READ_LATENCY=2 instance.
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 300) begin
            @(negedge clk); cyc++;
        end
        chk("rl2_done_seen", {63'd0, done2}, 64'd1);
        chk("rl2_done_cycle", 64'(cyc), 64'(2 * N * NP + 2));
        chk("rl2_pass", {63'd0, pass2}, 64'd1);
        chk("rl2_err", {60'd0, err_cnt2}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire
